// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the MEM pipeline stage:
//   mem_state_e          - bus-access FSM states (IDLE, ACCESS, DONE)
//   WORD_ALIGN_MASK      - low address bits that must be zero for a word access
//   DEFAULT_ACK_TIMEOUT  - default number of ACCESS cycles before an access is aborted
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_e;

  localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

  localparam int DEFAULT_ACK_TIMEOUT = 255;

endpackage

// File: rtl/mem_wb_register.sv
// mem_wb_register
// MEM/WB pipeline register with bubble insertion.
// Ports:
//   Clk, Reset            - clock, asynchronous active-high reset
//   bubble                - when high, the register captures a bubble
//   reg_write, mem_to_reg - control bits for the instruction leaving MEM
//   read_data             - load data for the instruction leaving MEM
//   alu_result            - ALU result for the instruction leaving MEM
//   write_register        - destination register for the instruction leaving MEM
//   wb_*                  - registered values presented to the WB stage
module mem_wb_register (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        bubble,
  input  logic        reg_write,
  input  logic        mem_to_reg,
  input  logic [31:0] read_data,
  input  logic [31:0] alu_result,
  input  logic [4:0]  write_register,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
  output logic [4:0]  wb_write_register
);

  // A bubble only needs to kill the register write; the data fields simply
  // hold, since WB ignores them when RegWrite is low.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wb_reg_write      <= 1'b0;
      wb_mem_to_reg     <= 1'b0;
      wb_read_data      <= '0;
      wb_alu_result     <= '0;
      wb_write_register <= '0;
    end else if (bubble) begin
      wb_reg_write      <= 1'b0;
    end else begin
      wb_reg_write      <= reg_write;
      wb_mem_to_reg     <= mem_to_reg;
      wb_read_data      <= read_data;
      wb_alu_result     <= alu_result;
      wb_write_register <= write_register;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
// MEM stage of the 5-stage MIPS32 pipeline.
//   - Resolves branches combinationally (PCSrc, Branch_Dest).
//   - Runs loads/stores over a req/ack data-memory bus, stalling upstream
//     stages (Stall_MEM) while an access is in flight, with an ack timeout.
//   - Registers the MEM/WB outputs (via mem_wb_register).
// Ports:
//   Clk, Reset                 - clock, asynchronous active-high reset
//   *_MEM inputs               - EX/MEM pipeline register contents
//   PCSrc, Branch_Dest         - branch redirect to IF
//   Stall_MEM                  - hold PC, IF/ID, ID/EX and EX/MEM
//   Mem_Req/We/Addr/Wdata      - data-memory request side
//   Mem_Rdata, Mem_Ack         - data-memory response side
//   *_WB outputs               - MEM/WB pipeline register contents
//   Addr_Error, Timeout_Error  - sticky error flags
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ACK_TIMEOUT = DEFAULT_ACK_TIMEOUT,
  parameter int CNT_W       = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        RegWrite_MEM,
  input  logic        MemtoReg_MEM,
  input  logic        Branch_MEM,
  input  logic        MemRead_MEM,
  input  logic        MemWrite_MEM,
  input  logic [31:0] Branch_Dest_MEM,
  input  logic        Zero_MEM,
  input  logic [31:0] ALU_Result_MEM,
  input  logic [31:0] Write_Data_MEM,
  input  logic [4:0]  Write_Register_MEM,
  output logic        PCSrc,
  output logic [31:0] Branch_Dest,
  output logic        Stall_MEM,
  output logic        Mem_Req,
  output logic        Mem_We,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_Wdata,
  input  logic [31:0] Mem_Rdata,
  input  logic        Mem_Ack,
  output logic        RegWrite_WB,
  output logic        MemtoReg_WB,
  output logic [31:0] Read_Data_WB,
  output logic [31:0] ALU_Result_WB,
  output logic [4:0]  Write_Register_WB,
  output logic        Addr_Error,
  output logic        Timeout_Error
);

  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(ACK_TIMEOUT - 1);

  mem_state_e       state;
  mem_state_e       next_state;
  logic [CNT_W-1:0] access_cnt;
  logic [31:0]      read_data_q;
  logic             access_aborted;
  logic             mem_op;
  logic             misaligned;
  logic             start_access;
  logic             ack_seen;
  logic             timed_out;
  logic             wb_reg_write_in;

  assign PCSrc       = Branch_MEM & Zero_MEM;
  assign Branch_Dest = Branch_Dest_MEM;

  assign mem_op     = MemRead_MEM | MemWrite_MEM;
  assign misaligned = mem_op && ((ALU_Result_MEM[1:0] & WORD_ALIGN_MASK) != 2'b00);

  // State register for the bus-access FSM.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and stall decode. Misaligned accesses never leave IDLE, so
  // they flow through in a single cycle without touching the bus.
  always_comb begin
    next_state   = state;
    start_access = 1'b0;
    ack_seen     = 1'b0;
    timed_out    = 1'b0;
    Stall_MEM    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_op && !misaligned) begin
          next_state   = ACCESS;
          start_access = 1'b1;
          Stall_MEM    = 1'b1;
        end
      end
      ACCESS: begin
        Stall_MEM = 1'b1;
        if (Mem_Ack) begin
          ack_seen   = 1'b1;
          next_state = DONE;
        end else if (access_cnt == LAST_COUNT) begin
          timed_out  = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Bus drive, timeout counter, load-data latch and sticky error flags.
  // The request fields are only loaded when an access starts, which keeps
  // them stable for the whole ACCESS phase.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      Mem_Req        <= 1'b0;
      Mem_We         <= 1'b0;
      Mem_Addr       <= '0;
      Mem_Wdata      <= '0;
      access_cnt     <= '0;
      read_data_q    <= '0;
      access_aborted <= 1'b0;
      Addr_Error     <= 1'b0;
      Timeout_Error  <= 1'b0;
    end else begin
      if (start_access) begin
        Mem_Req        <= 1'b1;
        Mem_We         <= MemWrite_MEM;
        Mem_Addr       <= ALU_Result_MEM;
        Mem_Wdata      <= Write_Data_MEM;
        access_cnt     <= '0;
        access_aborted <= 1'b0;
      end
      if (ack_seen) begin
        Mem_Req     <= 1'b0;
        read_data_q <= Mem_Rdata;
      end
      if (timed_out) begin
        Mem_Req        <= 1'b0;
        Timeout_Error  <= 1'b1;
        access_aborted <= 1'b1;
      end
      if (state == ACCESS && !ack_seen && !timed_out) begin
        access_cnt <= access_cnt + CNT_W'(1);
      end
      if (state == IDLE && misaligned) begin
        Addr_Error <= 1'b1;
      end
    end
  end

  // The aborted flag lingers after DONE, so it only suppresses the write for
  // the instruction whose access actually timed out.
  assign wb_reg_write_in = RegWrite_MEM && !misaligned &&
                           !(state == DONE && access_aborted);

  mem_wb_register u_mem_wb (
    .Clk               (Clk),
    .Reset             (Reset),
    .bubble            (Stall_MEM),
    .reg_write         (wb_reg_write_in),
    .mem_to_reg        (MemtoReg_MEM),
    .read_data         (read_data_q),
    .alu_result        (ALU_Result_MEM),
    .write_register    (Write_Register_MEM),
    .wb_reg_write      (RegWrite_WB),
    .wb_mem_to_reg     (MemtoReg_WB),
    .wb_read_data      (Read_Data_WB),
    .wb_alu_result     (ALU_Result_WB),
    .wb_write_register (Write_Register_WB)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
// Directed bench for mem_access_stage with a small WB scoreboard. Each
// instruction's expected WB result is pushed when it is driven and popped
// when the instruction reaches WB; bus and stall behaviour is checked per cycle.
module tb_mem_access_stage;

  localparam int TB_TIMEOUT = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        RegWrite_MEM, MemtoReg_MEM, Branch_MEM, MemRead_MEM, MemWrite_MEM;
  logic [31:0] Branch_Dest_MEM;
  logic        Zero_MEM;
  logic [31:0] ALU_Result_MEM, Write_Data_MEM;
  logic [4:0]  Write_Register_MEM;
  logic        PCSrc;
  logic [31:0] Branch_Dest;
  logic        Stall_MEM, Mem_Req, Mem_We;
  logic [31:0] Mem_Addr, Mem_Wdata, Mem_Rdata;
  logic        Mem_Ack;
  logic        RegWrite_WB, MemtoReg_WB;
  logic [31:0] Read_Data_WB, ALU_Result_WB;
  logic [4:0]  Write_Register_WB;
  logic        Addr_Error, Timeout_Error;

  typedef struct {
    logic        reg_write;
    logic        mem_to_reg;
    logic [31:0] alu_result;
    logic [4:0]  write_reg;
    logic [31:0] read_data;
  } wb_exp_t;

  wb_exp_t     expQ[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] lastAckData = 32'h0;

  always #5 Clk = ~Clk;

  mem_access_stage #(.ACK_TIMEOUT(TB_TIMEOUT), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset),
    .RegWrite_MEM(RegWrite_MEM), .MemtoReg_MEM(MemtoReg_MEM),
    .Branch_MEM(Branch_MEM), .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM),
    .Branch_Dest_MEM(Branch_Dest_MEM), .Zero_MEM(Zero_MEM),
    .ALU_Result_MEM(ALU_Result_MEM), .Write_Data_MEM(Write_Data_MEM),
    .Write_Register_MEM(Write_Register_MEM),
    .PCSrc(PCSrc), .Branch_Dest(Branch_Dest), .Stall_MEM(Stall_MEM),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Mem_Ack(Mem_Ack),
    .RegWrite_WB(RegWrite_WB), .MemtoReg_WB(MemtoReg_WB), .Read_Data_WB(Read_Data_WB),
    .ALU_Result_WB(ALU_Result_WB), .Write_Register_WB(Write_Register_WB),
    .Addr_Error(Addr_Error), .Timeout_Error(Timeout_Error)
  );

  task automatic checkWord(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clearInputs();
    RegWrite_MEM = 1'b0; MemtoReg_MEM = 1'b0; Branch_MEM = 1'b0;
    MemRead_MEM = 1'b0; MemWrite_MEM = 1'b0; Branch_Dest_MEM = 32'h0;
    Zero_MEM = 1'b0; ALU_Result_MEM = 32'h0; Write_Data_MEM = 32'h0;
    Write_Register_MEM = 5'd0;
  endtask

  // Drives one instruction into EX/MEM, pushes its expected WB result, plays
  // the memory side (ack on ACCESS cycle ackAt, 0 = never) and checks stall
  // and bus behaviour each cycle until the instruction reaches WB.
  task automatic applyStimulus(input string name, input logic rw, input logic mtr,
                               input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [4:0] wreg,
                               input int ackAt, input logic [31:0] rdata);
    wb_exp_t e;
    logic    memOp, mis, aligned, aborted, reqExp;
    int      n, total;
    memOp   = rd | wr;
    mis     = memOp && (addr[1:0] != 2'b00);
    aligned = memOp && !mis;
    aborted = 1'b0;
    n       = 0;
    if (aligned) begin
      if (ackAt >= 1 && ackAt <= TB_TIMEOUT) n = ackAt;
      else begin
        n = TB_TIMEOUT;
        aborted = 1'b1;
      end
    end
    total = aligned ? n + 2 : 1;
    if (aligned && !aborted) lastAckData = rdata;
    e.reg_write  = rw && !mis && !aborted;
    e.mem_to_reg = mtr;
    e.alu_result = addr;
    e.write_reg  = wreg;
    e.read_data  = lastAckData;
    expQ.push_back(e);

    RegWrite_MEM = rw; MemtoReg_MEM = mtr; MemRead_MEM = rd; MemWrite_MEM = wr;
    ALU_Result_MEM = addr; Write_Data_MEM = wdata; Write_Register_MEM = wreg;
    Branch_MEM = 1'b0; Zero_MEM = 1'b0;
    #1;
    for (int c = 0; c < total; c++) begin
      Mem_Ack   = aligned && !aborted && (c == n);
      Mem_Rdata = Mem_Ack ? rdata : $urandom;
      reqExp    = aligned && (c >= 1) && (c <= n);
      checkBit($sformatf("%s stall c%0d", name, c), Stall_MEM, aligned && (c < total - 1));
      checkBit($sformatf("%s req c%0d", name, c), Mem_Req, reqExp);
      if (reqExp) begin
        checkWord($sformatf("%s addr c%0d", name, c), Mem_Addr, addr);
        checkWord($sformatf("%s wdata c%0d", name, c), Mem_Wdata, wdata);
        checkBit($sformatf("%s we c%0d", name, c), Mem_We, wr);
      end
      if (c >= 1) checkBit($sformatf("%s bubble c%0d", name, c), RegWrite_WB, 1'b0);
      tick();
      Mem_Ack = 1'b0;
    end
  endtask

  // Pops the oldest expected WB result and compares it with the WB outputs.
  task automatic checkOutput(input string name);
    wb_exp_t e;
    checks++;
    assert (expQ.size() > 0) else begin
      failures++;
      $error("[TB] FAIL %s scoreboard observed=empty expected=entry", name);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkBit({name, " RegWrite_WB"}, RegWrite_WB, e.reg_write);
      checkBit({name, " MemtoReg_WB"}, MemtoReg_WB, e.mem_to_reg);
      checkWord({name, " ALU_Result_WB"}, ALU_Result_WB, e.alu_result);
      checkWord({name, " Write_Register_WB"}, {27'd0, Write_Register_WB}, {27'd0, e.write_reg});
      checkWord({name, " Read_Data_WB"}, Read_Data_WB, e.read_data);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=no finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset = 1'b1;
    clearInputs();
    Mem_Ack = 1'b0;
    Mem_Rdata = 32'h0;
    #2;
    checkBit("reset Mem_Req", Mem_Req, 1'b0);
    checkBit("reset RegWrite_WB", RegWrite_WB, 1'b0);
    checkWord("reset ALU_Result_WB", ALU_Result_WB, 32'h0);
    checkBit("reset Stall_MEM", Stall_MEM, 1'b0);
    checkBit("reset Addr_Error", Addr_Error, 1'b0);
    checkBit("reset Timeout_Error", Timeout_Error, 1'b0);
    Branch_MEM = 1'b1; Zero_MEM = 1'b1; Branch_Dest_MEM = 32'h55;
    #1;
    checkBit("reset PCSrc follows", PCSrc, 1'b1);
    checkWord("reset Branch_Dest follows", Branch_Dest, 32'h55);
    clearInputs();
    tick();
    Reset = 1'b0;
    tick();

    applyStimulus("alu", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234, 32'h0, 5'd7, 0, 32'h0);
    checkOutput("alu");

    applyStimulus("load", 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 5'd5, 3, 32'hDEADBEEF);
    checkOutput("load");

    applyStimulus("store", 1'b0, 1'b0, 1'b0, 1'b1, 32'h204, 32'hCAFEF00D, 5'd0, 1, 32'h11111111);
    checkOutput("store");

    applyStimulus("misaligned", 1'b1, 1'b1, 1'b1, 1'b0, 32'h102, 32'h0, 5'd9, 0, 32'h0);
    checkOutput("misaligned");
    checkBit("misaligned Addr_Error", Addr_Error, 1'b1);

    applyStimulus("rdwr", 1'b0, 1'b0, 1'b1, 1'b1, 32'h208, 32'h5A5A5A5A, 5'd0, 2, 32'h22222222);
    checkOutput("rdwr");
    checkBit("sticky Addr_Error", Addr_Error, 1'b1);
    checkBit("no Timeout_Error yet", Timeout_Error, 1'b0);

    applyStimulus("timeout", 1'b1, 1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 5'd3, 0, 32'h0);
    checkOutput("timeout");
    checkBit("timeout Timeout_Error", Timeout_Error, 1'b1);

    clearInputs();
    Branch_MEM = 1'b1; Zero_MEM = 1'b1; Branch_Dest_MEM = 32'h400;
    #1;
    checkBit("branch taken PCSrc", PCSrc, 1'b1);
    checkWord("branch Branch_Dest", Branch_Dest, 32'h400);
    Zero_MEM = 1'b0;
    #1;
    checkBit("branch not taken PCSrc", PCSrc, 1'b0);
    clearInputs();
    tick();

    applyStimulus("alu2", 1'b1, 1'b0, 1'b0, 1'b0, 32'hABC, 32'h0, 5'd12, 0, 32'h0);
    checkOutput("alu2");

    RegWrite_MEM = 1'b1; MemRead_MEM = 1'b1; ALU_Result_MEM = 32'h300;
    Write_Register_MEM = 5'd4;
    tick();
    checkBit("midreset Mem_Req before", Mem_Req, 1'b1);
    tick();
    #2;
    Reset = 1'b1;
    #1;
    checkBit("midreset Mem_Req", Mem_Req, 1'b0);
    checkBit("midreset Timeout_Error", Timeout_Error, 1'b0);
    checkBit("midreset Addr_Error", Addr_Error, 1'b0);
    checkBit("midreset RegWrite_WB", RegWrite_WB, 1'b0);
    checkBit("midreset MemtoReg_WB", MemtoReg_WB, 1'b0);
    checkWord("midreset ALU_Result_WB", ALU_Result_WB, 32'h0);
    checkWord("midreset Read_Data_WB", Read_Data_WB, 32'h0);
    checkWord("midreset Write_Register_WB", {27'd0, Write_Register_WB}, 32'h0);
    checkBit("midreset Stall_MEM follows", Stall_MEM, 1'b1);
    clearInputs();
    tick();
    Reset = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
